// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO and its read-side stream adapter.
// The reader state is fully described by (occupancy, read-in-flight).
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 8;
  localparam int ADDR_WIDTH_DEFAULT  = 5;
  localparam int COUNT_WIDTH_DEFAULT = 16;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;
  typedef logic [1:0]                    occ_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FILL,
    RD_ONE,
    RD_ONE_FILL,
    RD_FULL
  } rd_state_e;

  // Any other (occ, in_flight) pair breaks the occ + in_flight <= 2 invariant;
  // treating it as FULL stops further reads unless a word leaves.
  function automatic rd_state_e rd_state(input occ_t occ, input logic in_flight);
    case ({occ, in_flight})
      3'b000:  return RD_IDLE;
      3'b001:  return RD_FILL;
      3'b010:  return RD_ONE;
      3'b011:  return RD_ONE_FILL;
      default: return RD_FULL;
    endcase
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer absorbing the FIFO's one-cycle read latency.
// slot0 is always the head; pushes land at the tail and preserve arrival order.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  occ_t                  occ_q, occ_d;
  logic                  do_pop;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != 2'd0);

    case (occ_q)
      2'd0: begin
        if (push) begin
          slot0_d = push_data;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        case ({push, do_pop})
          2'b10: begin
            slot1_d = push_data;
            occ_d   = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          2'b11: slot0_d = push_data;
          default: ;
        endcase
      end
      2'd2: begin
        // A push without a pop here would overflow; the issue logic never allows it.
        if (do_pop) begin
          slot0_d = slot1_q;
          if (push) slot1_d = push_data;
          else      occ_d   = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data slots are reset too (only two words wide) so the stream data reads 0 out of reset.
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head = slot0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port onto a valid/ready stream at up to one word per cycle.
// Reads are issued only when the skid buffer is guaranteed a free slot at capture time.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] word_count
);

  occ_t                   occ;
  logic                   in_flight_q, in_flight_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   pop;
  logic                   has_room;
  rd_state_e              state;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  always_comb begin
    state    = rd_state(occ, in_flight_q);
    has_room = 1'b0;
    // With two words already committed, a new read only fits if one leaves this cycle.
    case (state)
      RD_IDLE, RD_FILL, RD_ONE: has_room = 1'b1;
      RD_ONE_FILL, RD_FULL:     has_room = pop;
      default:                  has_room = 1'b0;
    endcase

    fifo_rd_en   = !rst && !fifo_empty && has_room;
    in_flight_d  = fifo_rd_en;
    word_count_d = word_count_q + COUNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      in_flight_q  <= in_flight_d;
      word_count_q <= word_count_d;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight_q),
    .push_data(fifo_data),
    .pop      (pop),
    .head     (m_data),
    .occ      (occ)
  );

  assign word_count = word_count_q;

endmodule
